// File: rtl/fifo_rd_adapter_if.sv
// Bundle between fifo_rd_adapter and its surroundings: FIFO read side, output
// stream, and occupancy/in-flight debug taps for checkers.
interface fifo_rd_adapter_if #(
    parameter int DATA_W = 8
);
    // FIFO side: rdreq pops one word per cycle it is sampled high; data_out
    // carries that word exactly one cycle later. Stream side: a word moves
    // when m_valid && m_ready on a rising edge; m_valid/m_data stay stable
    // until that happens, and m_ready is ignored while m_valid is low.
    logic              rd_empty;
    logic              rdreq;
    logic [DATA_W-1:0] data_out;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        dbg_occ;
    logic              dbg_inflight;

    modport master (
        input  rd_empty,
        input  data_out,
        input  m_ready,
        output rdreq,
        output m_valid,
        output m_data,
        output dbg_occ,
        output dbg_inflight
    );

    modport slave (
        output rd_empty,
        output data_out,
        output m_ready,
        input  rdreq,
        input  m_valid,
        input  m_data,
        input  dbg_occ,
        input  dbg_inflight
    );
endinterface

// File: rtl/fifo_rd_adapter.sv
// Converts a FIFO read port (1-cycle read latency) into a valid/ready stream
// through a 2-entry skid buffer. FIFO_RD_STATS_EN adds a handshake counter.
module fifo_rd_adapter #(
    parameter int DATA_W = 8
) (
    input  logic                rd_clk,
    input  logic                rst,
    fifo_rd_adapter_if.master   bus,
    output logic [15:0]         xfer_cnt
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic              pop;
    logic              room;
    logic              rdreq;
    logic [1:0]        base;

    // Words already buffered plus the one arriving must never exceed two,
    // unless a pop frees a slot in the same cycle.
    always_comb begin
        pop   = (occ_q != 2'd0) && bus.m_ready;
        room  = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2;
        rdreq = !rst && !bus.rd_empty && (room || pop);
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = rdreq;
        base       = occ_q;
        if (pop) begin
            head_d = tail_q;
            base   = occ_q - 2'd1;
        end
        // Arriving word lands in the first free slot after the pop shift.
        if (inflight_q) begin
            if (base == 2'd0) begin
                head_d = bus.data_out;
            end else begin
                tail_d = bus.data_out;
            end
        end
        occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
        end
    end

    assign bus.rdreq        = rdreq;
    assign bus.m_valid      = (occ_q != 2'd0);
    assign bus.m_data       = head_q;
    assign bus.dbg_occ      = occ_q;
    assign bus.dbg_inflight = inflight_q;

`ifdef FIFO_RD_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pop) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Bench for fifo_rd_adapter: queue-based FIFO source, stream model and order
// scoreboard, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_fifo_rd_adapter;

    localparam int DATA_W = 8;
`ifdef FIFO_RD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] xfer_cnt;

    always #5 clk = ~clk;

    fifo_rd_adapter_if #(.DATA_W(DATA_W)) bus();

    fifo_rd_adapter #(.DATA_W(DATA_W)) dut (
        .rd_clk   (clk),
        .rst      (rst),
        .bus      (bus),
        .xfer_cnt (xfer_cnt)
    );

    // environment and scoreboard state
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              rdreq_seen = 1'b0;
    int                n_checks = 0;
    int                n_errors = 0;

    // stream model: words held by the adapter, plus one pending arrival
    logic [DATA_W-1:0] mbuf[$];
    bit                pend = 1'b0;
    logic [15:0]       exp_cnt = 16'd0;
    logic              exp_valid, exp_pop, exp_rdreq;

    // logs for directed scenarios
    int                cyc = 0;
    int                hs_total = 0;
    bit                log_en = 1'b1;
    int                rdreq_log[$];
    int                hs_log[$];
    logic [DATA_W-1:0] hs_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // compare process: runs mid-cycle once inputs have settled
    always @(negedge clk) begin
        #2;
        cyc++;
        if (rst) begin
            check("rst_rdreq", bus.rdreq, 1'b0);
            check("rst_m_valid", bus.m_valid, 1'b0);
            check("rst_m_data", bus.m_data, '0);
            check("rst_xfer_cnt", xfer_cnt, 16'd0);
            mbuf.delete();
            pend       = 1'b0;
            exp_cnt    = 16'd0;
            rdreq_seen = bus.rdreq;
        end else begin
            exp_valid = (mbuf.size() != 0);
            exp_pop   = exp_valid && bus.m_ready;
            exp_rdreq = !bus.rd_empty && (((mbuf.size() + int'(pend)) < 2) || exp_pop);
            check("rdreq", bus.rdreq, exp_rdreq);
            check("m_valid", bus.m_valid, exp_valid);
            if (exp_valid) begin
                check("m_data", bus.m_data, mbuf[0]);
            end
            check("occ", bus.dbg_occ, mbuf.size());
            check("inflight", bus.dbg_inflight, pend);
            check("xfer_cnt", xfer_cnt, STATS ? exp_cnt : 16'd0);
            if (bus.rdreq && !(bus.m_valid && bus.m_ready)) begin
                check("rdreq_room", (bus.dbg_occ + 2'(bus.dbg_inflight)) < 2'd2, 1'b1);
            end
            if (bus.m_valid && bus.m_ready) begin
                hs_total++;
                check("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check("sb_order", bus.m_data, exp_q.pop_front());
                end
                if (log_en) begin
                    hs_log.push_back(cyc);
                    hs_data.push_back(bus.m_data);
                end
            end
            if (log_en && bus.rdreq) begin
                rdreq_log.push_back(cyc);
            end
            if (exp_pop) begin
                void'(mbuf.pop_front());
                exp_cnt = exp_cnt + 16'd1;
            end
            if (pend) begin
                mbuf.push_back(bus.data_out);
            end
            pend       = bus.rdreq;
            rdreq_seen = bus.rdreq;
        end
    end

    // driver tasks
    task automatic cycle(input logic rdy, input logic rst_v);
        @(negedge clk);
        if (rdreq_seen && fifo_q.size() != 0) begin
            bus.data_out = fifo_q.pop_front();
        end
        if (rst_v && !rst) begin
            exp_q = fifo_q;
        end
        rst          = rst_v;
        bus.m_ready  = rdy;
        bus.rd_empty = (fifo_q.size() == 0);
        #3;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic clear_logs();
        rdreq_log.delete();
        hs_log.delete();
        hs_data.delete();
    endtask

    task automatic do_reset();
        fifo_q.delete();
        exp_q.delete();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        clear_logs();
    endtask

    initial begin
        bus.m_ready  = 1'b0;
        bus.rd_empty = 1'b1;
        bus.data_out = '0;
        repeat (3) cycle(1'b0, 1'b1);
        check("init_m_valid", bus.m_valid, 1'b0);

        // full-rate streaming of 0..9
        do_reset();
        for (int i = 0; i < 10; i++) push_word(8'(i));
        repeat (14) cycle(1'b1, 1'b0);
        check("s1_rdreq_count", rdreq_log.size(), 10);
        if (rdreq_log.size() == 10) check("s1_rdreq_span", rdreq_log[9] - rdreq_log[0], 9);
        check("s1_hs_count", hs_log.size(), 10);
        if (hs_log.size() == 10 && rdreq_log.size() != 0) begin
            check("s1_latency", hs_log[0] - rdreq_log[0], 2);
            check("s1_hs_span", hs_log[9] - hs_log[0], 9);
            for (int i = 0; i < 10; i++) check("s1_word", hs_data[i], 8'(i));
        end
        check("s1_drain", exp_q.size(), 0);

        // stall with 5 words, then release
        do_reset();
        for (int i = 0; i < 5; i++) push_word(8'hA0 + 8'(i));
        repeat (8) cycle(1'b0, 1'b0);
        check("s2_rdreq_pulses", rdreq_log.size(), 2);
        check("s2_m_valid", bus.m_valid, 1'b1);
        check("s2_m_data_held", bus.m_data, 8'hA0);
        check("s2_occ_full", bus.dbg_occ, 2'd2);
        check("s2_no_hs", hs_log.size(), 0);
        repeat (10) cycle(1'b1, 1'b0);
        check("s2_hs_count", hs_data.size(), 5);
        if (hs_data.size() == 5) begin
            for (int i = 0; i < 5; i++) check("s2_word", hs_data[i], 8'hA0 + 8'(i));
        end
        check("s2_drain", exp_q.size(), 0);

        // alternating ready
        do_reset();
        for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));
        for (int k = 0; k < 24; k++) cycle((k % 2) == 0, 1'b0);
        check("s3_hs_count", hs_data.size(), 8);
        if (hs_data.size() == 8) begin
            for (int i = 0; i < 8; i++) check("s3_word", hs_data[i], 8'h10 + 8'(i));
        end
        check("s3_idle", bus.m_valid, 1'b0);

        // empty FIFO throughout
        do_reset();
        repeat (20) cycle(1'b1, 1'b0);
        check("s4_no_rdreq", rdreq_log.size(), 0);
        check("s4_no_hs", hs_log.size(), 0);
        check("s4_m_valid", bus.m_valid, 1'b0);

        // reset while a word is buffered and another is in flight
        do_reset();
        for (int i = 0; i < 20; i++) push_word(8'h40 + 8'(i));
        repeat (5) cycle(1'b1, 1'b0);
        check("s5_pre_hs", hs_data.size(), 3);
        check("s5_pre_occ", bus.dbg_occ, 2'd1);
        check("s5_pre_inflight", bus.dbg_inflight, 1'b1);
        cycle(1'b1, 1'b1);
        check("s5_rst_m_valid", bus.m_valid, 1'b0);
        check("s5_rst_m_data", bus.m_data, 8'h00);
        check("s5_rst_xfer_cnt", xfer_cnt, 16'd0);
        clear_logs();
        repeat (25) cycle(1'b1, 1'b0);
        check("s5_post_hs", hs_data.size(), 15);
        if (hs_data.size() == 15) begin
            for (int i = 0; i < 15; i++) check("s5_word", hs_data[i], 8'h45 + 8'(i));
        end
        check("s5_drain", exp_q.size(), 0);

        // 65537 handshakes: counter wraps to 1 when enabled, stays 0 otherwise
        do_reset();
        log_en   = 1'b0;
        hs_total = 0;
        for (int k = 0; k < 66000; k++) begin
            if (fifo_q.size() < 4) push_word(8'(k));
            cycle(1'b1, 1'b0);
            if (hs_total >= 65537) break;
        end
        cycle(1'b0, 1'b0);
        check("s6_hs_total", hs_total, 65537);
        check("s6_xfer_cnt", xfer_cnt, STATS ? 16'd1 : 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
